// File: rtl/cv32e40p_shadow_obi_mux.sv
// Two-to-one OBI data-port mux between the LSU and the shadow-register save controller.
// Shadow wins arbitration, a waiting request is held until granted, and responses are steered by an in-order ID FIFO.
module cv32e40p_shadow_obi_mux #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        lsu_req_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,

  input  logic        shadow_req_i,
  output logic        shadow_gnt_o,
  output logic        shadow_rvalid_o,
  input  logic        shadow_we_i,
  input  logic [3:0]  shadow_be_i,
  input  logic [31:0] shadow_addr_i,
  input  logic [31:0] shadow_wdata_i,
  output logic [31:0] shadow_rdata_o,

  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,

  output logic        idle_o
);

  localparam int unsigned          PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic                 SRC_LSU    = 1'b0;
  localparam logic                 SRC_SHADOW = 1'b1;

  logic                 lock_q, lock_d;
  logic                 lock_src_q, lock_src_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic                 id_q [MAX_OUTSTANDING];

  logic sel_vld;
  logic sel_src;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A locked source keeps the port even against a newer shadow request; a full FIFO blocks new issue.
  always_comb begin
    sel_vld = 1'b0;
    sel_src = SRC_LSU;
    if (lock_q) begin
      sel_vld = 1'b1;
      sel_src = lock_src_q;
    end else if (cnt_q == CNT_MAX) begin
      sel_vld = 1'b0;
    end else if (shadow_req_i) begin
      sel_vld = 1'b1;
      sel_src = SRC_SHADOW;
    end else if (lsu_req_i) begin
      sel_vld = 1'b1;
    end
  end

  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    if (sel_vld) begin
      if (sel_src == SRC_SHADOW) begin
        data_req_o   = shadow_req_i;
        data_we_o    = shadow_we_i;
        data_be_o    = shadow_be_i;
        data_addr_o  = shadow_addr_i;
        data_wdata_o = shadow_wdata_i;
      end else begin
        data_req_o   = lsu_req_i;
        data_we_o    = lsu_we_i;
        data_be_o    = lsu_be_i;
        data_addr_o  = lsu_addr_i;
        data_wdata_o = lsu_wdata_i;
      end
    end
  end

  assign push         = data_req_o & data_gnt_i;
  assign lsu_gnt_o    = push & (sel_src == SRC_LSU);
  assign shadow_gnt_o = push & (sel_src == SRC_SHADOW);

  // A response with nothing outstanding is ignored rather than corrupting the FIFO.
  assign head            = id_q[rptr_q];
  assign pop             = data_rvalid_i & (cnt_q != '0);
  assign lsu_rvalid_o    = pop & (head == SRC_LSU);
  assign shadow_rvalid_o = pop & (head == SRC_SHADOW);
  assign lsu_rdata_o     = data_rdata_i;
  assign shadow_rdata_o  = data_rdata_i;

  assign idle_o = (cnt_q == '0) & ~lock_q;

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (data_req_o && !data_gnt_i) begin
      lock_d     = 1'b1;
      lock_src_d = sel_src;
    end else if (push) begin
      lock_d = 1'b0;
    end
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_LSU;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // ID storage is only meaningful behind the counter, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wptr_q] <= sel_src;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(data_rvalid_i && (cnt_q == '0)))
        else $error("obi_mux: rvalid received with no transaction outstanding");
      assert (cnt_q <= CNT_MAX)
        else $error("obi_mux: outstanding count above limit");
    end
  end
`endif

endmodule

// File: doc/cv32e40p_shadow_obi_mux.md
# cv32e40p_shadow_obi_mux

Two-to-one OBI data-port multiplexer between the core LSU and the shadow-register save controller, placed downstream of the save controller and upstream of the core data memory interface. It arbitrates requests with fixed shadow priority and holds the selected source until grant, as OBI requires. It records the source of every granted transaction in an in-order ID FIFO and routes each `rvalid` back to the master that issued it.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum number of granted transactions awaiting `rvalid`. Must be ≥1.
- `CNT_WIDTH`, default `$clog2(MAX_OUTSTANDING+1)`: width of the outstanding counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`  in  1  clock.
  - `rst_ni`  in  1  reset, asynchronous, active-low.
- LSU side (OBI slave):
  - `lsu_req_i`  in  1
  - `lsu_gnt_o`  out  1
  - `lsu_rvalid_o`  out  1
  - `lsu_we_i`  in  1
  - `lsu_be_i`  in  4
  - `lsu_addr_i`  in  32
  - `lsu_wdata_i`  in  32
  - `lsu_rdata_o`  out  32
- Shadow save controller side (OBI slave):
  - `shadow_req_i`  in  1
  - `shadow_gnt_o`  out  1
  - `shadow_rvalid_o`  out  1
  - `shadow_we_i`  in  1
  - `shadow_be_i`  in  4
  - `shadow_addr_i`  in  32
  - `shadow_wdata_i`  in  32
  - `shadow_rdata_o`  out  32
- Memory side (OBI master):
  - `data_req_o`  out  1
  - `data_gnt_i`  in  1
  - `data_rvalid_i`  in  1
  - `data_we_o`  out  1
  - `data_be_o`  out  4
  - `data_addr_o`  out  32
  - `data_wdata_o`  out  32
  - `data_rdata_i`  in  32
- Status:
  - `idle_o`  out  1: high when nothing is outstanding and no request is locked.

## Operation
State:
- `lock_q`, `lock_src_q`: lock flag and locked source (0 = LSU, 1 = shadow).
- ID FIFO of depth `MAX_OUTSTANDING` (1-bit source ID) with read/write pointers.
- `cnt_q`: outstanding-transaction counter.

Source selection, in priority order:
1. `lock_q` = 1: the selected source is `lock_src_q`.
2. `cnt_q == MAX_OUTSTANDING`: no source is selected, and `data_req_o` = 0.
3. `shadow_req_i` = 1: shadow is selected.
4. `lsu_req_i` = 1: LSU is selected.
5. Otherwise no request.

Request path:
- `data_req_o` = the `req` of the selected source.
- `data_we/be/addr/wdata` = the selected source's fields, or all zeros when nothing is selected.
- The selected source's `gnt` = `data_req_o & data_gnt_i`. The other source's `gnt` = 0.

Lock:
- When `data_req_o` = 1 and `data_gnt_i` = 0, set `lock_q` = 1 and `lock_src_q` = the selected source.
- When `data_req_o` and `data_gnt_i` are both high, clear `lock_q`.
- A locked LSU request is not pre-empted by a newly arriving `shadow_req_i`.

Push and pop:
- Push: on `data_req_o && data_gnt_i`, write the source ID at the write pointer, advance the write pointer, and increment `cnt_q`.
- Pop: on `data_rvalid_i`, the head ID selects which output carries the response:
  - `lsu_rvalid_o` = `data_rvalid_i & (head == 0)`.
  - `shadow_rvalid_o` = `data_rvalid_i & (head == 1)`.
  - The read pointer advances and `cnt_q` decrements.
- Push and pop in the same cycle leave `cnt_q` unchanged. Both pointers advance, wrapping at `MAX_OUTSTANDING`.

Response data and status:
- `lsu_rdata_o` = `shadow_rdata_o` = `data_rdata_i`, passed through unconditionally.
- `idle_o` = (`cnt_q` == 0) & !`lock_q`.

Protocol violations:
- `data_rvalid_i` with `cnt_q == 0`: both `rvalid` outputs stay 0, and pointers and counter are unchanged. A simulation assertion flags it.
- A simulation assertion also flags `cnt_q` exceeding `MAX_OUTSTANDING`.

Reset values:
- `cnt_q` = 0, both pointers = 0, `lock_q` = 0, `lock_src_q` = 0.
- With request inputs low, all `req`, `gnt` and `rvalid` outputs are 0, and `idle_o` = 1.
- Reset asserted mid-transaction clears all state immediately. Responses still in flight at that point are dropped.

## Timing
- Request and grant are purely combinational through the block, with zero added latency. Data fields follow the same path.
- Response routing is combinational from `data_rvalid_i` and the registered FIFO head, with zero latency.
- There is no combinational path from `data_rvalid_i` to `data_req_o`. A full FIFO blocks new requests even in a cycle where a pop occurs; the request is issued the following cycle.
- State updates on the rising edge of `clk_i`.
- Back-to-back grants are allowed every cycle while `cnt_q < MAX_OUTSTANDING`.

## Test plan
- **Priority:** `lsu_req_i` and `shadow_req_i` both high from idle, `data_gnt_i` = 1 → `shadow_gnt_o` = 1 and `data_addr_o` = `shadow_addr_i`. The LSU is granted in the next cycle. Later `rvalid`s arrive in the order shadow, then LSU.
- **Lock:** LSU request with `data_gnt_i` = 0 for 3 cycles, with shadow asserted in cycle 2 → `data_addr_o` stays `lsu_addr_i` until the grant. Shadow is granted only after the LSU grant.
- **FIFO full:** `MAX_OUTSTANDING` = 2, two LSU grants with no `rvalid`, then a shadow request → `data_req_o` = 0. Assert `data_rvalid_i` → `lsu_rvalid_o` = 1, and `data_req_o` = 1 in the next cycle.
- **Save burst:** 7 shadow writes, each granted, with `rvalid` one cycle after each grant → 7 `shadow_rvalid_o` pulses, 0 `lsu_rvalid_o` pulses, and `idle_o` = 1 after the last response.
- **Simultaneous push/pop:** grant and `rvalid` in the same cycle with `cnt_q` = 1 → `cnt_q` stays 1, and pointers wrap correctly across 10 iterations.
- **Reset:** assert `rst_ni` low with 2 transactions outstanding → `cnt_q` = 0 and `idle_o` = 1 immediately, and all outputs are 0.
